booth_r4_mult: RTL and testbench

- Parametrised radix-4 (modified Booth) sequential multiplier; next generation of the 8-bit radix-2 Booth multiplier.
- Generalised in operand width; adds a signed/unsigned mode, an explicit busy/done handshake and an asynchronous reset.
- Processes two multiplier bits per cycle.
- Sits in the datapath as a shared arithmetic unit driven by a controller or testbench via start/done.

---
 rtl/booth_r4_mult_pkg.sv | 22 ++
 rtl/booth_r4_mult_if.sv | 22 ++
 rtl/booth_r4_mult_recoder.sv | 27 ++
 rtl/booth_r4_mult.sv | 124 ++++++++++++
 tb/tb_booth_r4_mult.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/booth_r4_mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Each digit code is the recoder's {zero, two, neg} output triple.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit 2 = zero, bit 1 = double M, bit 0 = negate.
  localparam logic [2:0] ZERO   = 3'b100;
  localparam logic [2:0] PLUS1  = 3'b000;
  localparam logic [2:0] PLUS2  = 3'b010;
  localparam logic [2:0] MINUS1 = 3'b001;
  localparam logic [2:0] MINUS2 = 3'b011;

  function automatic int calc_iter(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_mult_if.sv
// Start/done handshake bundle between a controller and the Booth multiplier.
interface booth_r4_mult_if #(
  parameter int W = 8
);
  logic             start;
  logic             signed_mode;
  logic [W-1:0]     X;
  logic [W-1:0]     Y;
  logic [2*W-1:0]   produs;
  logic             busy;
  logic             done;

  modport master (
    output start, signed_mode, X, Y,
    input  produs, busy, done
  );

  modport slave (
    input  start, signed_mode, X, Y,
    output produs, busy, done
  );
endinterface

// File: rtl/booth_r4_mult_recoder.sv
// Modified-Booth recoder: maps the window {q1, q0, q_m1} to a signed digit
// in {-2,-1,0,+1,+2}, presented as {zero, two, neg}.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output logic       zero,
  output logic       two,
  output logic       neg
);

  logic [2:0] digit;

  always_comb begin
    digit = ZERO;
    case (win)
      3'b001, 3'b010: digit = PLUS1;
      3'b011:         digit = PLUS2;
      3'b100:         digit = MINUS2;
      3'b101, 3'b110: digit = MINUS1;
      default:        digit = ZERO;
    endcase
  end

  assign {zero, two, neg} = digit;

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Operands carry two extra bits so unsigned inputs finish on a non-negative digit.
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_r4_mult_if.slave  bus
);

  localparam int ITER = calc_iter(W);
  localparam int CW   = $clog2(ITER + 1);

  if (W < 4 || W > 32 || (W % 2) != 0) begin : g_bad_width
    $error("booth_r4_mult: W must be even and within 4..32");
  end

  state_t            state_q, state_d;
  logic [W+1:0]      m_q, m_d;
  logic [W+1:0]      q_q, q_d;
  logic [W+3:0]      a_q, a_d;
  logic              qm1_q, qm1_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*W-1:0]    produs_q, produs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              dig_zero, dig_two, dig_neg;
  logic [W+3:0]      m_ext, mag, addend, a_sum, a_next;
  logic [W+1:0]      q_next;

  booth_r4_recoder u_recoder (
    .win  ({q_q[1:0], qm1_q}),
    .zero (dig_zero),
    .two  (dig_two),
    .neg  (dig_neg)
  );

  // One Booth step: add the recoded digit times M, then shift {A,Q,q_m1} right by two.
  always_comb begin
    m_ext  = {{2{m_q[W+1]}}, m_q};
    mag    = dig_two ? {m_ext[W+2:0], 1'b0} : m_ext;
    addend = dig_zero ? '0 : (dig_neg ? -mag : mag);
    a_sum  = a_q + addend;
    a_next = {{2{a_sum[W+3]}}, a_sum[W+3:2]};
    q_next = {a_sum[1:0], q_q[W+1:2]};
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    a_d      = a_q;
    qm1_d    = qm1_q;
    count_d  = count_q;
    produs_d = produs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          m_d     = bus.signed_mode ? {{2{bus.X[W-1]}}, bus.X} : {2'b00, bus.X};
          q_d     = bus.signed_mode ? {{2{bus.Y[W-1]}}, bus.Y} : {2'b00, bus.Y};
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_next;
        q_d     = q_next;
        qm1_d   = q_q[1];
        count_d = count_q + CW'(1);
        if (count_q == CW'(ITER - 1)) begin
          produs_d = {a_next[W-3:0], q_next};
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      qm1_q    <= 1'b0;
      count_q  <= '0;
      produs_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      a_q      <= a_d;
      qm1_q    <= qm1_d;
      count_q  <= count_d;
      produs_q <= produs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.produs = produs_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult: W=8 and W=16 instances compared
// against a plain-arithmetic product model.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  booth_r4_mult_if #(.W(8))  b8 ();
  booth_r4_mult_if #(.W(16)) b16 ();

  booth_r4_mult #(.W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  booth_r4_mult #(.W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Exact 2w-bit product from integer arithmetic on the interpreted operands.
  function automatic logic [31:0] refProduct(input logic [15:0] x, input logic [15:0] y,
                                             input bit sgn, input int w);
    longint xs, ys, p, mask;
    mask = (longint'(1) << w) - 1;
    xs = longint'(x) & mask;
    ys = longint'(y) & mask;
    if (sgn && x[w-1]) xs = xs - (longint'(1) << w);
    if (sgn && y[w-1]) ys = ys - (longint'(1) << w);
    p = xs * ys;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // One-cycle start, then count cycles until done and confirm it is a single pulse.
  task automatic applyStimulus(input bit wide, input logic [15:0] x, input logic [15:0] y,
                               input bit sgn, output int lat, output logic [31:0] res);
    @(negedge clk);
    if (wide) begin
      b16.X = x; b16.Y = y; b16.signed_mode = sgn; b16.start = 1'b1;
    end else begin
      b8.X = x[7:0]; b8.Y = y[7:0]; b8.signed_mode = sgn; b8.start = 1'b1;
    end
    @(negedge clk);
    b8.start  = 1'b0;
    b16.start = 1'b0;
    checkOutput("busy_after_start", 64'(wide ? b16.busy : b8.busy), 64'(1));
    lat = 0;
    while (!(wide ? b16.done : b8.done) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = wide ? b16.produs : {16'h0, b8.produs};
    @(negedge clk);
    checkOutput("done_single_pulse", 64'(wide ? b16.done : b8.done), 64'(0));
    checkOutput("busy_back_idle", 64'(wide ? b16.busy : b8.busy), 64'(0));
  endtask

  task automatic runOp(input string tag, input bit wide, input logic [15:0] x, input logic [15:0] y,
                       input bit sgn, input logic [31:0] expected);
    int          lat;
    logic [31:0] res;
    applyStimulus(wide, x, y, sgn, lat, res);
    checkOutput(tag, 64'(res), 64'(expected));
    checkOutput({tag, "_latency"}, 64'(lat), wide ? 64'(9) : 64'(5));
  endtask

  logic [15:0] hsRes[$];
  int          doneSeen;
  logic [15:0] rx, ry;
  bit          rs;

  initial begin
    rst_n = 1'b0;
    b8.start = 1'b0;  b8.signed_mode = 1'b0;  b8.X = '0;  b8.Y = '0;
    b16.start = 1'b0; b16.signed_mode = 1'b0; b16.X = '0; b16.Y = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_produs8", 64'(b8.produs), 64'(0));
    checkOutput("reset_busy8", 64'(b8.busy), 64'(0));
    checkOutput("reset_done8", 64'(b8.done), 64'(0));
    checkOutput("reset_produs16", 64'(b16.produs), 64'(0));
    checkOutput("reset_busy16", 64'(b16.busy), 64'(0));
    rst_n = 1'b1;

    for (int x = 0; x <= 10; x++)
      runOp($sformatf("table_%0dx6", x), 1'b0, 16'(x), 16'd6, 1'b0, 32'(x * 6));

    runOp("s_fa_x_07", 1'b0, 16'h00FA, 16'h0007, 1'b1, 32'h0000FFD6);
    runOp("s_80_x_80", 1'b0, 16'h0080, 16'h0080, 1'b1, 32'h00004000);
    runOp("s_80_x_7f", 1'b0, 16'h0080, 16'h007F, 1'b1, 32'h0000C080);
    runOp("u_ff_x_ff", 1'b0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01);
    runOp("u_80_x_02", 1'b0, 16'h0080, 16'h0002, 1'b0, 32'h00000100);

    // Held start: two operations back to back, X changed mid-RUN of the first.
    @(negedge clk);
    b8.X = 8'd3; b8.Y = 8'd5; b8.signed_mode = 1'b0; b8.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) b8.X = 8'd9;
      if (b8.done) hsRes.push_back(b8.produs);
    end
    b8.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b8.done) hsRes.push_back(b8.produs);
    end
    checkOutput("hold_start_ops", 64'(hsRes.size()), 64'(2));
    if (hsRes.size() >= 1) checkOutput("hold_start_first", 64'(hsRes[0]), 64'(15));
    if (hsRes.size() >= 2) checkOutput("hold_start_second", 64'(hsRes[1]), 64'(45));

    // Reset asserted in the third RUN cycle.
    @(negedge clk);
    b8.X = 8'd5; b8.Y = 8'd5; b8.signed_mode = 1'b0; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_produs", 64'(b8.produs), 64'(0));
    checkOutput("abort_busy", 64'(b8.busy), 64'(0));
    checkOutput("abort_done", 64'(b8.done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (b8.done) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'(0));
    checkOutput("abort_produs_held", 64'(b8.produs), 64'(0));
    runOp("after_abort_7x9", 1'b0, 16'd7, 16'd9, 1'b0, 32'd63);

    runOp("w16_s_8000sq", 1'b1, 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    runOp("w16_u_ffffsq", 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);

    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom & 32'hFF);
      ry = 16'($urandom & 32'hFF);
      rs = 1'($urandom_range(0, 1));
      runOp($sformatf("rand8_%0h_%0h_s%0d", rx, ry, rs), 1'b0, rx, ry, rs, refProduct(rx, ry, rs, 8));
    end
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      runOp($sformatf("rand16_%0h_%0h_s%0d", rx, ry, rs), 1'b1, rx, ry, rs, refProduct(rx, ry, rs, 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
